// File: rtl/uart8_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
//   arb_state_t : arbiter FSM encodings (idle / holding a byte / frame in flight)
//   idx_w()     : index width for NUM_REQ requesters, never less than 1 bit
package uart8_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD   = 2'd1,
    ARB_FLIGHT = 2'd2
  } arb_state_t;

  localparam int BYTE_W = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart8_tx_arbiter_rr_picker.sv
// Combinational round-robin select.
//   mask : eligible requesters
//   ptr  : highest-priority index this round
//   gnt  : one-hot winner (zero when nothing eligible)
//   idx  : winner index
//   any  : at least one requester eligible
module rr_picker
  import uart8_tx_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    off;
  logic [IW:0]    sum;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then map the
  // offset back to an absolute index with a single wrap.
  always_comb begin
    dbl = {mask, mask} >> ptr;
    rot = dbl[N-1:0];
    any = 1'b0;
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        off = (IW+1)'(k);
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    idx = sum[IW-1:0];
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/uart8_tx_arbiter.sv
// Round-robin front end sharing one Uart8Transmitter among NUM_REQ producers.
// Runs on the baud clock, holds one byte and drives the transmitter directly.
//   clk, rst            : baud clock, async active-high reset
//   en                  : block enable (0 drops held byte, clears lock)
//   req_valid/data/last : per-requester byte offer, data byte i at [8i+7:8i]
//   req_ready           : one-hot 1-cycle capture pulse
//   grant_id            : requester of the most recently captured byte
//   tx_en/start/data    : to transmitter en/start/in
//   tx_busy/tx_done     : from transmitter busy/done
//   idle                : nothing held and no frame in flight
module uart8_tx_arbiter
  import uart8_tx_arbiter_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter bit  LOCK_PACKETS = 1'b1,
  localparam int IW           = idx_w(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [8*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]    req_last,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [IW-1:0]         grant_id,
  output logic                  tx_en,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy,
  input  logic                  tx_done,
  output logic                  idle
);

  arb_state_t          state, state_n;
  logic                start_n;
  logic [7:0]          data_n;
  logic [NUM_REQ-1:0]  ready_n;
  logic [IW-1:0]       gid_n;
  logic [IW-1:0]       ptr, ptr_n;
  logic                lock_on, lock_on_n;
  logic [IW-1:0]       lock_id, lock_id_n;
  logic                pb, pd;

  logic [NUM_REQ-1:0]  lock_mask, elig, pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic                accept, room, cap;

  // Busy rising from idle, or busy held while done falls (chained frame),
  // marks the transmitter latching the held byte. tx_start doubles as the
  // "register full" flag.
  assign accept = tx_start & tx_busy & ~tx_done & (~pb | pd);

  // A requester whose ready pulse is out this cycle is mid-handshake; its
  // valid still shows the byte already taken, so it must not win again.
  assign lock_mask = lock_on ? (NUM_REQ'(1) << lock_id) : '1;
  assign elig      = req_valid & ~req_ready & lock_mask;

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .mask (elig),
    .ptr  (ptr),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Register is free in IDLE/FLIGHT, or in HOLD on the cycle it is accepted.
  assign room = (state == ARB_IDLE) | (state == ARB_FLIGHT) | ((state == ARB_HOLD) & accept);
  assign cap  = en & room & pick_any;

  always_comb begin
    state_n   = state;
    start_n   = tx_start;
    data_n    = tx_data;
    ready_n   = '0;
    gid_n     = grant_id;
    ptr_n     = ptr;
    lock_on_n = lock_on;
    lock_id_n = lock_id;
    if (!en) begin
      state_n   = ARB_IDLE;
      start_n   = 1'b0;
      lock_on_n = 1'b0;
    end else begin
      if (accept) start_n = 1'b0;
      case (state)
        ARB_HOLD:   if (accept) state_n = ARB_FLIGHT;
        ARB_FLIGHT: if (!tx_busy) state_n = ARB_IDLE;
        ARB_IDLE:   state_n = ARB_IDLE;
        default:    state_n = ARB_IDLE;
      endcase
      if (cap) begin
        state_n = ARB_HOLD;
        start_n = 1'b1;
        data_n  = req_data[{pick_idx, 3'b000} +: 8];
        ready_n = pick_gnt;
        gid_n   = pick_idx;
        ptr_n   = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
        if (LOCK_PACKETS) begin
          lock_on_n = ~req_last[pick_idx];
          lock_id_n = pick_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      req_ready <= '0;
      grant_id  <= '0;
      ptr       <= '0;
      lock_on   <= 1'b0;
      lock_id   <= '0;
      tx_en     <= 1'b0;
      pb        <= 1'b0;
      pd        <= 1'b0;
    end else begin
      state     <= state_n;
      tx_start  <= start_n;
      tx_data   <= data_n;
      req_ready <= ready_n;
      grant_id  <= gid_n;
      ptr       <= ptr_n;
      lock_on   <= lock_on_n;
      lock_id   <= lock_id_n;
      tx_en     <= en;
      pb        <= tx_busy;
      pd        <= tx_done;
    end
  end

  assign idle = (state == ARB_IDLE);

endmodule
